// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one instruction-memory read per instruction,
// holds the returned word for the downstream stages, and computes the next PC
// (sequential, branch, JAL or JALR) when the held instruction retires.
// A misaligned next PC parks the stage in a sticky error state until reset.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   Branch/Jal/Jalr   - control decode of the held instruction
//   zero              - branch-condition flag from the ALU
//   imm32, ReadData1  - immediate and rs1 value for target computation
//   stall             - downstream not ready; hold the current instruction
//   imem_req/addr     - memory read request and byte address
//   imem_rdata/ack    - memory read data and completion strobe
//   inst, pc          - held instruction word and its address
//   pc_plus4          - link value, combinational pc+4
//   inst_valid        - inst/pc valid for downstream
//   misalign_err      - sticky misaligned-target error
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Branch,
    input  logic        Jal,
    input  logic        Jalr,
    input  logic        zero,
    input  logic [31:0] imm32,
    input  logic [31:0] ReadData1,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    output logic        misalign_err
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] next_pc;

    // Target selection; JALR has highest priority and clears bit 0.
    always_comb begin
        next_pc = pc + 32'd4;
        if (Jalr) begin
            next_pc = (ReadData1 + imm32) & ~32'h0000_0001;
        end else if (Jal) begin
            next_pc = pc + imm32;
        end else if (Branch && zero) begin
            next_pc = pc + imm32;
        end
    end

    // State, PC and instruction register; reset abandons any open request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
            pc    <= RESET_PC;
            inst  <= NOP_INST;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        inst  <= imem_rdata;
                        state <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (!stall) begin
                        pc    <= next_pc;
                        state <= (next_pc[1:0] != 2'b00) ? S_ERR : S_REQ;
                    end
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    // Status outputs decode directly from the state register.
    assign imem_req     = (state == S_REQ);
    assign inst_valid   = (state == S_VALID);
    assign misalign_err = (state == S_ERR);
    assign imem_addr    = pc;
    assign pc_plus4     = pc + 32'd4;

endmodule
